// File: rtl/tanh_deriv_seq.sv
// ============================================================================
// tanh_deriv_seq
// ----------------------------------------------------------------------------
// Backward pass of the piecewise-linear tanh activation in the LSTM datapath:
//
//     grad = (1 - y*y) * delta
//
// y is the stored forward tanh output and delta is the upstream gradient.
// Both are signed fixed point with FRAC fractional bits, so 1.0 = 1 << FRAC.
//
// The two products share one radix-2 shift-add multiplier. Each product
// takes WIDTH cycles.
//   - The first pass squares |y|, after |y| is clamped to 1.0.
//   - One cycle then forms m = 1.0 - y^2.
//   - The second pass multiplies m by |delta|.
// The sign of delta is applied at the end. The sign of y drops out because
// y is squared.
//
// Timing at the defaults:
//   - o_valid rises on the 65th edge after the accepting edge (2*WIDTH+1).
//   - One result every 67 cycles (2*WIDTH+3) when i_ready is held high.
//
// Parameters
//   WIDTH    data width, two's complement
//   FRAC     number of fractional bits
//
// Ports
//   clk      system clock; all logic runs on the rising edge
//   rst      synchronous reset, active-high; aborts any operation in flight
//   i_valid  input operands valid
//   o_ready  block can accept operands (high only while idle)
//   i_y      forward tanh output y
//   i_delta  upstream gradient
//   o_valid  o_grad is valid; held until i_ready
//   i_ready  downstream accepts o_grad
//   o_grad   (1 - y^2) * delta, saturated to the signed WIDTH range
// ============================================================================
module tanh_deriv_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_delta,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_grad
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH);
    // Width of the product once the FRAC fraction bits are dropped. It is
    // wider than WIDTH, so overflow can be seen before saturation.
    localparam int PW = 2 * WIDTH - FRAC;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,   // waiting for operands
        SQR,    // |y| * |y| on the shared multiplier
        SUB,    // m = 1.0 - y^2
        MUL,    // m * |delta| on the shared multiplier
        DONE    // result presented, waiting for i_ready
    } state_t;

    state_t state, state_next;

    // Iteration counter, shared by both multiplier passes.
    logic [CW-1:0]      cnt;

    // Shift-add multiplier.
    //   mcand  : multiplicand, shifts left once per iteration
    //   mplier : multiplier, shifts right once per iteration
    //   acc    : running sum of the partial products
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    // Operands captured at accept time.
    logic [WIDTH-1:0]   d_mag;
    logic               d_sign;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   y_abs;
    logic [WIDTH-1:0]   y_clamped;
    logic [WIDTH-1:0]   d_abs;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   m_val;
    logic [PW-1:0]      prod_hi;
    logic               prod_sat;
    logic [WIDTH-1:0]   grad_val;
    logic               last_iter;

    // Absolute values are read as unsigned WIDTH-bit numbers. For the most
    // negative input the negation wraps back to itself, and as an unsigned
    // number that is 2^(WIDTH-1), which is the correct magnitude.
    // For y, that magnitude then clamps to 1.0.
    assign y_abs     = i_y[WIDTH-1] ? (~i_y + 1'b1) : i_y;
    assign y_clamped = (y_abs >= ONE) ? ONE : y_abs;
    assign d_abs     = i_delta[WIDTH-1] ? (~i_delta + 1'b1) : i_delta;

    assign acc_step  = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == LAST);

    // Because |y| <= 1.0, y^2 >> FRAC is at most 1.0. So m never goes
    // negative, and it fits in WIDTH bits.
    assign m_val     = ONE - acc[FRAC +: WIDTH];

    // Result of the final MUL iteration, with the fraction truncated.
    // Only |delta| = 2^(WIDTH-1) with m = 1.0 can overflow the positive range.
    assign prod_hi   = acc_step[2*WIDTH-1:FRAC];
    assign prod_sat  = |prod_hi[PW-1:WIDTH-1];

    always_comb begin
        // NOTE: every always_comb output is given a default first, so that no
        // path through the block leaves it unassigned and infers a latch.
        grad_val = prod_hi[WIDTH-1:0];
        if (prod_sat) begin
            grad_val = d_sign ? NEG_MIN : POS_MAX;
        end else if (d_sign) begin
            // Negating zero gives zero again, so the output is never -0.
            grad_val = ~prod_hi[WIDTH-1:0] + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking
        // assignments, so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (i_valid)   state_next = SQR;
            SQR:  if (last_iter) state_next = SUB;
            SUB:                 state_next = MUL;
            MUL:  if (last_iter) state_next = DONE;
            DONE: if (i_ready)   state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the counter and the visible result are reset. The
            // multiplier and operand registers are always loaded at accept
            // before they are read, so resetting them would only add reset
            // fan-out.
            cnt    <= '0;
            o_grad <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, y_clamped};
                        mplier <= y_clamped;
                        acc    <= '0;
                        d_mag  <= d_abs;
                        d_sign <= i_delta[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                SQR: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= last_iter ? '0 : cnt + 1'b1;
                end
                SUB: begin
                    // Reload the shared multiplier for the second product.
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, d_mag};
                    mplier <= m_val;
                    cnt    <= '0;
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= last_iter ? '0 : cnt + 1'b1;
                    // Capture the result on the same edge that enters DONE,
                    // so o_grad is valid when o_valid rises.
                    if (last_iter) begin
                        o_grad <= grad_val;
                    end
                end
                DONE: begin
                    // o_grad holds until the output handshake completes.
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Handshake outputs, decoded from the state register
    // ------------------------------------------------------------------------
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_tanh_deriv_seq.sv
// Testbench for tanh_deriv_seq. Expected results come from an arithmetic
// model of (1 - y^2) * delta built on 64-bit integers.
module tb_tanh_deriv_seq;

    localparam longint ONE_L = 64'sd1 << 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_y;
    logic [31:0] i_delta;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_grad;

    int total = 0;
    int fails = 0;

    tanh_deriv_seq #(.WIDTH(32), .FRAC(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_y     (i_y),
        .i_delta (i_delta),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_grad  (o_grad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: fixed-point arithmetic done directly on 64-bit integers.
    function automatic logic [31:0] model(input logic [31:0] y, input logic [31:0] d);
        longint ya, da, m, mag;
        ya = longint'($signed(y));
        if (ya < 0) ya = -ya;
        if (ya > ONE_L) ya = ONE_L;
        m  = ONE_L - ((ya * ya) / ONE_L);
        da = longint'($signed(d));
        if (da < 0) da = -da;
        mag = (m * da) / ONE_L;
        if (d[31] == 1'b0) begin
            return (mag > 64'sd2147483647) ? 32'h7FFF_FFFF : 32'(mag);
        end else begin
            return (mag > 64'sd2147483648) ? 32'h8000_0000 : 32'(-mag);
        end
    endfunction

    // Run one operation.
    //   y, d : operands
    //   hold : cycles to keep i_ready low after o_valid rises
    //   exp  : expected o_grad
    task automatic do_op(input string tag, input logic [31:0] y, input logic [31:0] d,
                         input int hold, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        check({tag, ".ready_before"}, 64'(o_ready), 64'd1);
        i_y = y; i_delta = d; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble the inputs after accept; they must have no effect.
        i_valid = 1'b0; i_y = $urandom; i_delta = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!o_valid && lat < 200);
        check({tag, ".latency"}, 64'(lat), 64'd65);
        check({tag, ".grad"}, 64'(o_grad), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(o_valid), 64'd1);
            check({tag, ".hold_grad"}, 64'(o_grad), 64'(exp));
            check({tag, ".hold_ready"}, 64'(o_ready), 64'd0);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".valid_after"}, 64'(o_valid), 64'd0);
        check({tag, ".ready_after"}, 64'(o_ready), 64'd1);
        i_ready = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] ry, rd;
        int acc_edge[2];
        int n;
        int waited;

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_y = '0; i_delta = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", 64'(o_ready), 64'd1);
        check("reset.valid", 64'(o_valid), 64'd0);
        check("reset.grad", 64'(o_grad), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_op("y0_d1",      32'h0000_0000, 32'h0100_0000, 0, 32'h0100_0000);
        do_op("yhalf_d1",   32'h0080_0000, 32'h0100_0000, 0, 32'h00C0_0000);
        do_op("ynhalf_dn2", 32'hFF80_0000, 32'hFE00_0000, 0, 32'hFE80_0000);
        do_op("clamp_one",  32'h0100_0000, 32'h0040_0000, 0, 32'h0000_0000);
        do_op("clamp_two",  32'h0200_0000, 32'h0040_0000, 0, 32'h0000_0000);
        do_op("clamp_min",  32'h8000_0000, 32'h0040_0000, 0, 32'h0000_0000);
        do_op("zero_neg",   32'h0100_0000, 32'hFFC0_0000, 0, 32'h0000_0000);
        do_op("sat_neg",    32'h0000_0000, 32'h8000_0000, 0, 32'h8000_0000);
        do_op("backpress",  32'h0080_0000, 32'hFE00_0000, 10, 32'hFE80_0000);

        // Randomised cases checked against the model.
        for (int k = 0; k < 24; k++) begin
            ry = 32'($urandom_range(0, 32'h0180_0000));
            if ($urandom_range(0, 1) == 1) ry = ~ry + 32'd1;
            if (k % 6 == 5) ry = $urandom;
            rd = $urandom;
            do_op($sformatf("rand%0d", k), ry, rd, k % 3, model(ry, rd));
        end

        // Reset asserted at edge 20 of a computation. o_grad holds the last,
        // nonzero result, so its reset to zero is observable.
        do_op("pre_abort", 32'h0000_0000, 32'h0300_0000, 0, 32'h0300_0000);
        @(negedge clk);
        i_y = 32'h0040_0000; i_delta = 32'h0100_0000; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.ready", 64'(o_ready), 64'd1);
        check("abort.valid", 64'(o_valid), 64'd0);
        check("abort.grad", 64'(o_grad), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_abort", 32'h0080_0000, 32'h0100_0000, 0, 32'h00C0_0000);

        // Throughput with i_valid and i_ready both held high.
        n = 0;
        @(negedge clk);
        i_y = 32'h0080_0000; i_delta = 32'h0100_0000; i_valid = 1'b1; i_ready = 1'b1;
        for (int e = 0; e < 140; e++) begin
            if (o_ready && n < 2) begin
                acc_edge[n] = e;
                n++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("tput.accepts", 64'(n), 64'd2);
        if (n == 2) check("tput.period", 64'(acc_edge[1] - acc_edge[0]), 64'd67);
        waited = 0;
        while (!o_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tput.drain", 64'(o_ready), 64'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
